// File: rtl/motion_pkg.sv
// motion_pkg
// Shared types and helpers for the LiDAR motion-correction datapath.
// Holds the Q16.16 word and timestamp typedefs, the point struct that the
// timestamper hands to top_motion_corrector, and the tick-to-seconds
// reciprocal used to turn tick deltas into Q16.16 seconds.
`timescale 1ns/1ps
package motion_pkg;

    localparam int WP        = 32;
    localparam int TSW       = 32;
    localparam int FRAC_BITS = 16;

    typedef logic signed [WP-1:0] q16_16_t;
    typedef logic [TSW-1:0]       ts_t;

    typedef struct packed {
        q16_16_t px;
        q16_16_t py;
        q16_16_t pz;
    } point_t;

    // floor(2^32 / tick_hz): seconds-per-tick as an unsigned Q0.32 fraction.
    // Multiplying a tick count by this and dropping 16 bits gives Q16.16 seconds.
    function automatic logic [31:0] recip_q0_32(input longint unsigned tick_hz);
        logic [63:0] w_quot;
        w_quot = 64'h1_0000_0000 / 64'(tick_hz);
        return w_quot[31:0];
    endfunction

endpackage

// File: rtl/scan_point_timestamper_pipe_stage.sv
// pipe_stage
// Generic single-entry valid/ready register slice.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid/o_ready     upstream handshake (o_ready: slot free or draining)
//   i_data              upstream payload, W bits
//   o_valid/i_ready     downstream handshake
//   o_data              registered payload, held while o_valid && !i_ready
`timescale 1ns/1ps
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // The slot can take new data when it is empty or its content leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/scan_point_timestamper.sv
// scan_point_timestamper
// Converts raw LiDAR point beats (Q16.16 xyz + tick timestamp) into
// (px, py, pz, dt) for the motion corrector. dt is the time since the most
// recent start-of-frame point, in Q16.16 seconds, clamped to MAX_DT_TICKS.
// Also measures the scan period between consecutive start-of-frame points.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_valid/s_ready                   input handshake
//   s_px/s_py/s_pz, s_ts, s_sof       input point, timestamp, first-of-scan flag
//   m_valid/m_ready                   output handshake
//   m_px/m_py/m_pz, m_dt, m_sof, m_sat output point, dt (Q16.16 s), sof, clamp flag
//   period_ticks, period_valid        last scan period and its one-cycle update pulse
//   drop_cnt                          saturating count of points seen before any sof
`timescale 1ns/1ps
module scan_point_timestamper
    import motion_pkg::*;
#(
    parameter int WP           = 32,
    parameter int TSW          = 32,
    parameter int TICK_HZ      = 1000000,
    parameter int MAX_DT_TICKS = 250000,
    parameter int DROPW        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WP-1:0]    s_px,
    input  logic [WP-1:0]    s_py,
    input  logic [WP-1:0]    s_pz,
    input  logic [TSW-1:0]   s_ts,
    input  logic             s_sof,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WP-1:0]    m_px,
    output logic [WP-1:0]    m_py,
    output logic [WP-1:0]    m_pz,
    output logic [WP-1:0]    m_dt,
    output logic             m_sof,
    output logic             m_sat,
    output logic [TSW-1:0]   period_ticks,
    output logic             period_valid,
    output logic [DROPW-1:0] drop_cnt
);

    localparam logic [63:0]    RECIP  = 64'(recip_q0_32(longint'(TICK_HZ)));
    localparam logic [TSW-1:0] MAX_DT = TSW'(MAX_DT_TICKS);
    localparam int S1W = 3*WP + TSW + 2;
    localparam int S2W = 4*WP + 2;

    logic             r_live;
    logic [TSW-1:0]   r_base_ts;
    logic             r_have_base;
    logic [TSW-1:0]   r_period;
    logic             r_period_valid;
    logic [DROPW-1:0] r_drop;

    logic             w_s1_in_valid;
    logic             w_s1_ready;
    logic             w_accept;
    logic [TSW-1:0]   w_raw_delta;
    logic [TSW-1:0]   w_delta;
    logic             w_sat;
    logic [S1W-1:0]   w_s1_in;
    logic             w_s1_valid;
    logic [S1W-1:0]   w_s1_data;
    logic             w_s2_ready;

    logic [WP-1:0]    w_s1_px;
    logic [WP-1:0]    w_s1_py;
    logic [WP-1:0]    w_s1_pz;
    logic [TSW-1:0]   w_s1_delta;
    logic             w_s1_sof;
    logic             w_s1_sat;
    logic [63:0]      w_prod;
    logic [WP-1:0]    w_dt;
    logic [S2W-1:0]   w_s2_in;
    logic [S2W-1:0]   w_s2_data;

    // Holds s_ready low while in reset and for the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign s_ready  = r_live && w_s1_ready;
    assign w_accept = s_valid && s_ready;

    // Points arriving before the first sof are consumed but never enter the pipe.
    assign w_s1_in_valid = s_valid && r_live && (s_sof || r_have_base);

    // Unsigned subtraction absorbs timestamp wrap-around.
    assign w_raw_delta = s_ts - r_base_ts;

    always_comb begin
        w_delta = w_raw_delta;
        w_sat   = 1'b0;
        if (s_sof) begin
            w_delta = '0;
        end else if (w_raw_delta > MAX_DT) begin
            w_delta = MAX_DT;
            w_sat   = 1'b1;
        end
    end

    // Scan base, period measurement and pre-sof drop counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base_ts      <= '0;
            r_have_base    <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_drop         <= '0;
        end else begin
            r_period_valid <= 1'b0;
            if (w_accept) begin
                if (s_sof) begin
                    if (r_have_base) begin
                        r_period       <= s_ts - r_base_ts;
                        r_period_valid <= 1'b1;
                    end
                    r_base_ts   <= s_ts;
                    r_have_base <= 1'b1;
                end else if (!r_have_base && (r_drop != '1)) begin
                    r_drop <= r_drop + 1'b1;
                end
            end
        end
    end

    assign w_s1_in = {s_px, s_py, s_pz, w_delta, s_sof, w_sat};

    pipe_stage #(.W(S1W)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_in_valid),
        .o_ready (w_s1_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_data)
    );

    assign {w_s1_px, w_s1_py, w_s1_pz, w_s1_delta, w_s1_sof, w_s1_sat} = w_s1_data;

    // Ticks to Q16.16 seconds; the product fits well below 2^(WP+16) for any
    // legal clamp, so truncating after the shift loses nothing.
    assign w_prod = 64'(w_s1_delta) * RECIP;
    assign w_dt   = WP'(w_prod >> FRAC_BITS);

    assign w_s2_in = {w_s1_px, w_s1_py, w_s1_pz, w_dt, w_s1_sof, w_s1_sat};

    pipe_stage #(.W(S2W)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (w_s2_data)
    );

    assign {m_px, m_py, m_pz, m_dt, m_sof, m_sat} = w_s2_data;

    assign period_ticks = r_period;
    assign period_valid = r_period_valid;
    assign drop_cnt     = r_drop;

endmodule

// File: doc/scan_point_timestamper.md
Name: scan_point_timestamper

Overview:
- Upstream neighbour of top_motion_corrector: converts raw LiDAR point beats (Q16.16 xyz plus a hardware tick timestamp) into the (px, py, pz, dt) form the corrector consumes.
- Latches the scan-start timestamp on each start-of-frame point and computes per-point dt in Q16.16 seconds, with wrap-safe subtraction and saturation.
- Measures the scan period between consecutive start-of-frame points.
- Forwards points through a 2-stage valid/ready pipeline.

Parameters:
- WP, 32, point/dt word width (signed Q16.16)
- TSW, 32, timestamp width (unsigned ticks)
- TICK_HZ, 1000000, timestamp tick rate
- MAX_DT_TICKS, 250000, delta clamp; larger deltas saturate to this value
- DROPW, 16, width of the drop counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- s_valid  in  1  input point valid
- s_ready  out  1  input point accepted when s_valid && s_ready
- s_px/s_py/s_pz  in  WP  point coordinates, Q16.16
- s_ts  in  TSW  point timestamp, ticks
- s_sof  in  1  first point of a scan
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- m_px/m_py/m_pz  out  WP  coordinates, passed through unchanged
- m_dt  out  WP  time since scan start, Q16.16 seconds, >= 0
- m_sof  out  1  passed-through sof
- m_sat  out  1  dt was clamped
- period_ticks  out  TSW  last measured scan period
- period_valid  out  1  one-cycle pulse when period_ticks updates
- drop_cnt  out  DROPW  points discarded before the first sof; saturating

Behaviour:
- Reset (rst_n low, asynchronous) clears all of the following:
  - outputs 0: m_valid, m_*, period_ticks, period_valid, drop_cnt
  - internal state: base_ts = 0, have_base = 0, both pipeline stages empty
  - s_ready reads 0 while rst_n is low.
  - Reset mid-stream discards in-flight points. Nothing is emitted after deassert until a new accepted beat.
- Accept: a beat is accepted on a clk edge with s_valid && s_ready.
- Stage 1 (on accept):
  - sof = 1: delta = 0.
    - If have_base, period_ticks <= s_ts - base_ts (mod 2^TSW) and period_valid pulses next cycle.
    - Then base_ts <= s_ts and have_base <= 1.
  - sof = 0 and have_base: delta = (s_ts - base_ts) mod 2^TSW, so timestamp wrap is handled by unsigned subtraction.
    - If delta > MAX_DT_TICKS, delta = MAX_DT_TICKS and sat = 1.
  - sof = 0 and !have_base: the beat is consumed, not forwarded; drop_cnt += 1, saturating at all ones.
- Stage 2: m_dt = (delta * RECIP) >> 16 with RECIP = floor(2^32 / TICK_HZ).
  - The product is unsigned, 64-bit; truncate toward zero.
  - Upper bits are guaranteed 0 for legal parameters. RECIP = 4294 at the default TICK_HZ.
- Latency: 2 cycles from accept to m_valid when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - Each stage advances when it is empty or the next stage is taking its data; s_ready = stage1 empty || stage1 advancing.
  - m_* are held stable while m_valid && !m_ready.
  - m_valid never drops without a handshake.
- Simultaneous sof beats back-to-back: each rebases. Their periods are measured from the previous base.
- period_valid is a single-cycle pulse. It is not held by m_ready stalls, because it is tied to the accept, not the output.

Decomposition:
- motion_pkg holds:
  - WP, TSW
  - the Q16.16 typedef (signed [WP-1:0])
  - the ts typedef
  - the constant function recip_q0_32(tick_hz)
  - the point struct {px, py, pz}, shared with top_motion_corrector
- One sub-module, pipe_stage: a generic valid/ready register stage parameterised on payload width, instantiated twice.

Test Plan:
- Reset, then a sof beat with ts=1000 followed by ts=101000, m_ready=1:
  - outputs m_dt=0 then m_dt=6552 (100000*4294>>16), each 2 cycles after accept
  - m_sof=1 then 0.
- Three beats before any sof:
  - no m_valid
  - drop_cnt=3, s_ready stays 1
  - the next sof beat is forwarded.
- Wrap: sof ts=0xFFFFFFF0, next ts=0x00000010 -> delta 32 -> m_dt=2, m_sat=0.
- Saturation: sof ts=0, next ts=400000 -> m_dt=16380, m_sat=1.
- Period: sof at ts=5000, then sof at ts=205000 -> period_ticks=200000, period_valid high exactly 1 cycle; second beat m_dt=0.
- Backpressure and reset:
  - Hold m_ready=0 for 5 cycles with 4 beats offered: s_ready falls after 2 accepted; m_* stable. Release: all beats emerge in order, none lost.
  - Assert rst_n low mid-stall: m_valid=0 immediately.
